// File: rtl/multdiv_unit_if.sv
// Start/operand/result handshake between the execute stage (master) and the
// iterative multiply/divide unit (slave).
interface multdiv_unit_if #(parameter int WIDTH = 32);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 shift-add) / divide (non-restoring) unit.
// Define MULTDIV_BOOTH4_EN to switch multiply to radix-4 Booth, WIDTH/2 iterations.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           reset,
    multdiv_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef MULTDIV_BOOTH4_EN
    localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH / 2);
`else
    localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH);
`endif
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic             r_negResult;
    logic             r_divZero;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH+1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic             r_exception;
    logic             r_ready;
    logic             r_busy;

    logic               w_start;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [2*WIDTH-1:0] w_signedProd;
    logic               w_prodOvf;
    logic [WIDTH+1:0]   w_divShift;
    logic [WIDTH+1:0]   w_divRem;
    logic [WIDTH-1:0]   w_signedQuot;
    logic               w_quotOvf;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_absA  = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign w_absB  = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

`ifdef MULTDIV_BOOTH4_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_bMcand;
    logic [WIDTH:0]     r_bMplier;
    logic [2*WIDTH-1:0] w_boothAdd;

    // Booth digit from the overlapping triplet {b(2i+1), b(2i), b(2i-1)}
    always_comb begin
        w_boothAdd = '0;
        case (r_bMplier[2:0])
            3'b001, 3'b010: w_boothAdd = r_bMcand;
            3'b011:         w_boothAdd = r_bMcand << 1;
            3'b100:         w_boothAdd = -(r_bMcand << 1);
            3'b101, 3'b110: w_boothAdd = -r_bMcand;
            default:        w_boothAdd = '0;
        endcase
    end

    assign w_signedProd = r_acc;
`else
    logic [WIDTH:0]     w_multSum;
    logic [2*WIDTH-1:0] w_magProd;

    assign w_multSum    = {1'b0, r_hi[WIDTH-1:0]} + (r_lo[0] ? {1'b0, r_opB} : '0);
    assign w_magProd    = {r_hi[WIDTH-1:0], r_lo};
    assign w_signedProd = r_negResult ? -w_magProd : w_magProd;
`endif

    // Product fits in WIDTH bits only when the top WIDTH+1 bits are a pure sign extension
    assign w_prodOvf = ~((&w_signedProd[2*WIDTH-1:WIDTH-1]) | ~(|w_signedProd[2*WIDTH-1:WIDTH-1]));

    // Remainder carries two extra bits so 2R +/- divisor never wraps
    assign w_divShift   = {r_hi[WIDTH:0], r_lo[WIDTH-1]};
    assign w_divRem     = r_hi[WIDTH+1] ? (w_divShift + {2'b00, r_opB})
                                        : (w_divShift - {2'b00, r_opB});
    assign w_signedQuot = r_negResult ? -r_lo : r_lo;
    assign w_quotOvf    = ~r_negResult & r_lo[WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_negResult <= 1'b0;
            r_divZero   <= 1'b0;
            r_opB       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
            r_acc       <= '0;
            r_bMcand    <= '0;
            r_bMplier   <= '0;
`endif
        end else begin
            r_ready <= 1'b0;
            // A start always wins, aborting any operation in flight
            if (w_start) begin
                r_count     <= '0;
                r_busy      <= 1'b1;
                r_hi        <= '0;
                r_negResult <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                r_divZero   <= (bus.data_operandB == '0);
                if (bus.ctrl_MULT) begin
                    r_state <= MULT;
                    r_lo    <= w_absB;
                    r_opB   <= w_absA;
`ifdef MULTDIV_BOOTH4_EN
                    r_acc     <= '0;
                    r_bMcand  <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                    r_bMplier <= {bus.data_operandB, 1'b0};
`endif
                end else begin
                    r_state <= DIV;
                    r_lo    <= w_absA;
                    r_opB   <= w_absB;
                end
            end else begin
                case (r_state)
                    MULT: begin
                        if (r_count == MULT_LAST) begin
                            r_result    <= w_signedProd[WIDTH-1:0];
                            r_exception <= w_prodOvf;
                            r_ready     <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= DONE;
                        end else begin
`ifdef MULTDIV_BOOTH4_EN
                            r_acc     <= r_acc + w_boothAdd;
                            r_bMcand  <= r_bMcand << 2;
                            r_bMplier <= {{2{r_bMplier[WIDTH]}}, r_bMplier[WIDTH:2]};
`else
                            r_hi <= {2'b00, w_multSum[WIDTH:1]};
                            r_lo <= {w_multSum[0], r_lo[WIDTH-1:1]};
`endif
                            r_count <= r_count + 1'b1;
                        end
                    end
                    DIV: begin
                        if (r_count == DIV_LAST) begin
                            r_result    <= r_divZero ? '0 : w_signedQuot;
                            r_exception <= r_divZero | w_quotOvf;
                            r_ready     <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            r_hi    <= w_divRem;
                            r_lo    <= {r_lo[WIDTH-2:0], ~w_divRem[WIDTH+1]};
                            r_count <= r_count + 1'b1;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exception;
    assign bus.data_resultRDY = r_ready;
    assign bus.busy           = r_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed edge cases, randomized operations
// against a plain-arithmetic reference model, restart, done-overlap and reset-abort.
module tb_multdiv_unit;

    localparam int WIDTH = 32;
`ifdef MULTDIV_BOOTH4_EN
    localparam int MUL_LAT = WIDTH / 2 + 1;
`else
    localparam int MUL_LAT = WIDTH + 1;
`endif
    localparam int DIV_LAT = WIDTH + 1;
    localparam int TIMEOUT = 60;

    logic clock = 1'b0;
    logic reset;
    int   compareCount = 0;
    int   failCount = 0;

    multdiv_unit_if #(.WIDTH(WIDTH)) bus ();

    multdiv_unit #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: exact 64-bit signed arithmetic, exception when not representable in 32 bits
    function automatic void refModel(input bit isMult, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] res,
                                     output logic exc);
        longint full;
        longint lowExt;
        if (!isMult && b == 32'h0) begin
            res = 32'h0;
            exc = 1'b1;
            return;
        end
        if (isMult) full = longint'($signed(a)) * longint'($signed(b));
        else        full = longint'($signed(a)) / longint'($signed(b));
        res    = full[31:0];
        lowExt = longint'($signed(res));
        exc    = (full != lowExt);
    endfunction

    // Called at a negedge; returns at the negedge following start edge E0
    task automatic applyStimulus(input bit isMult, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = isMult;
        bus.ctrl_DIV      = !isMult;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom();
        bus.data_operandB = $urandom();
    endtask

    task automatic waitReady(input logic [31:0] held, output int edges,
                             output bit busyOk, output bit stableOk);
        edges    = 0;
        busyOk   = 1'b1;
        stableOk = 1'b1;
        while (bus.data_resultRDY !== 1'b1 && edges < TIMEOUT) begin
            if (bus.busy !== 1'b1) busyOk = 1'b0;
            if (bus.data_result !== held) stableOk = 1'b0;
            @(posedge clock);
            @(negedge clock);
            edges++;
        end
        if (bus.busy !== 1'b0) busyOk = 1'b0;
    endtask

    task automatic runOp(input string tag, input bit isMult, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input logic expExc);
        int          edges;
        bit          busyOk;
        bit          stableOk;
        logic [31:0] held;
        held = bus.data_result;
        applyStimulus(isMult, a, b);
        waitReady(held, edges, busyOk, stableOk);
        checkOutput({tag, ".latency"}, 64'(edges), 64'(isMult ? MUL_LAT : DIV_LAT));
        checkOutput({tag, ".result"}, 64'(bus.data_result), 64'(expRes));
        checkOutput({tag, ".exception"}, 64'(bus.data_exception), 64'(expExc));
        checkOutput({tag, ".busy"}, 64'(busyOk), 64'(1));
        checkOutput({tag, ".stable"}, 64'(stableOk), 64'(1));
        @(posedge clock);
        @(negedge clock);
        checkOutput({tag, ".pulseWidth"}, 64'(bus.data_resultRDY), 64'(0));
        checkOutput({tag, ".hold"}, 64'(bus.data_result), 64'(expRes));
    endtask

    initial begin
        int          pulses;
        int          firstEdge;
        int          edges;
        bit          busyOk;
        bit          stableOk;
        logic [31:0] capRes;
        logic        capExc;

        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset.result", 64'(bus.data_result), 64'(0));
        checkOutput("reset.exception", 64'(bus.data_exception), 64'(0));
        checkOutput("reset.ready", 64'(bus.data_resultRDY), 64'(0));
        checkOutput("reset.busy", 64'(bus.busy), 64'(0));
        reset = 1'b0;
        @(negedge clock);

        runOp("mul7xm3",    1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        runOp("mulOvf",     1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        runOp("mulM1xM1",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        runOp("mulMinxM1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        runOp("mulMinx1",   1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0);
        runOp("divM7by2",   1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        runOp("divByZero",  1'b0, 32'd100,      32'd0,        32'h00000000, 1'b1);
        runOp("divMinByM1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        runOp("divMaxBy1",  1'b0, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0);

        for (int i = 0; i < 32; i++) begin
            bit          isMult;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] er;
            logic        ee;
            isMult = (i % 2 == 0);
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 3))
                1: begin
                    a = {{16{a[15]}}, a[15:0]};
                    b = {{16{b[15]}}, b[15:0]};
                end
                2: b = 32'h0;
                3: begin
                    a = 32'h80000000;
                    b = {{28{b[3]}}, b[3:0]};
                end
                default: ;
            endcase
            refModel(isMult, a, b, er, ee);
            runOp($sformatf("rand%0d", i), isMult, a, b, er, ee);
        end

        // Restart: multiply aborted ten cycles in by a divide
        pulses    = 0;
        firstEdge = -1;
        capRes    = '0;
        capExc    = 1'b0;
        applyStimulus(1'b1, 32'd5, 32'd6);
        repeat (9) begin
            if (bus.data_resultRDY === 1'b1) pulses++;
            @(posedge clock);
            @(negedge clock);
        end
        if (bus.data_resultRDY === 1'b1) pulses++;
        applyStimulus(1'b0, 32'd20, 32'd3);
        for (int e = 0; e < TIMEOUT; e++) begin
            if (bus.data_resultRDY === 1'b1) begin
                pulses++;
                if (firstEdge < 0) begin
                    firstEdge = e;
                    capRes    = bus.data_result;
                    capExc    = bus.data_exception;
                end
            end
            @(posedge clock);
            @(negedge clock);
        end
        checkOutput("restart.pulses", 64'(pulses), 64'(1));
        checkOutput("restart.latency", 64'(firstEdge), 64'(DIV_LAT));
        checkOutput("restart.result", 64'(capRes), 64'(6));
        checkOutput("restart.exception", 64'(capExc), 64'(0));

        // New start presented in the same cycle as the ready pulse
        applyStimulus(1'b1, 32'hFFFFFFF0, 32'd3);
        waitReady(32'h00000006, edges, busyOk, stableOk);
        checkOutput("overlap.first.latency", 64'(edges), 64'(MUL_LAT));
        checkOutput("overlap.first.ready", 64'(bus.data_resultRDY), 64'(1));
        checkOutput("overlap.first.result", 64'(bus.data_result), 64'(32'hFFFFFFD0));
        applyStimulus(1'b0, 32'hFFFFFF9C, 32'd7);
        waitReady(32'hFFFFFFD0, edges, busyOk, stableOk);
        checkOutput("overlap.second.latency", 64'(edges), 64'(DIV_LAT));
        checkOutput("overlap.second.result", 64'(bus.data_result), 64'(32'hFFFFFFF2));
        checkOutput("overlap.second.exception", 64'(bus.data_exception), 64'(0));
        checkOutput("overlap.second.busy", 64'(busyOk), 64'(1));
        checkOutput("overlap.second.stable", 64'(stableOk), 64'(1));
        @(posedge clock);
        @(negedge clock);

        // Reset in the middle of a divide
        applyStimulus(1'b0, 32'd1000, 32'd7);
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
        end
        checkOutput("resetAbort.busyBefore", 64'(bus.busy), 64'(1));
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("resetAbort.busy", 64'(bus.busy), 64'(0));
        checkOutput("resetAbort.result", 64'(bus.data_result), 64'(0));
        checkOutput("resetAbort.exception", 64'(bus.data_exception), 64'(0));
        pulses = 0;
        repeat (40) begin
            if (bus.data_resultRDY === 1'b1) pulses++;
            @(posedge clock);
            @(negedge clock);
        end
        checkOutput("resetAbort.pulses", 64'(pulses), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
